// File: rtl/serial_deframer.sv
// Serial deframer: hunts for a sync pattern in the strobed bit stream, then assembles
// FRAME_WORDS words MSB-first and presents them through a one-word valid/ready buffer.
module serial_deframer #(
  parameter int                    WIDTH        = 32,
  parameter int                    SYNC_WIDTH   = 8,
  parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 8'hA5,
  parameter int                    FRAME_WORDS  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clken,
  input  logic             si,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             locked,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int BCW = $clog2(WIDTH);
  localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_WORDS - 1);

  typedef enum logic {HUNT, ASSEMBLE} state_t;

  state_t                state_reg, state_next;
  logic [SYNC_WIDTH-1:0] window_reg;
  logic [WIDTH-1:0]      acc_reg;
  logic [BCW-1:0]        bit_cnt_reg;
  logic [WCW-1:0]        word_cnt_reg;
  logic [WIDTH-1:0]      m_data_reg;
  logic                  m_valid_reg;
  logic                  overflow_reg;

  logic [SYNC_WIDTH-1:0] window_shift;
  logic [WIDTH-1:0]      word_shift;
  logic                  sync_hit, word_done, last_word, load, drop;

  assign window_shift = {window_reg[SYNC_WIDTH-2:0], si};
  assign word_shift   = {acc_reg[WIDTH-2:0], si};
  assign sync_hit     = clken && (state_reg == HUNT) && (window_shift == SYNC_PATTERN);
  assign word_done    = clken && (state_reg == ASSEMBLE) && (bit_cnt_reg == BIT_LAST);
  assign last_word    = (word_cnt_reg == WORD_LAST);
  // A completed word is accepted if the buffer is empty or is being drained at this same edge.
  assign load         = word_done && (!m_valid_reg || m_ready);
  assign drop         = word_done && !load;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= HUNT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HUNT:     if (sync_hit) state_next = ASSEMBLE;
      ASSEMBLE: if (word_done && last_word) state_next = HUNT;
      default:  state_next = HUNT;
    endcase
  end

  always_comb begin
    locked = (state_reg == ASSEMBLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      window_reg   <= ~SYNC_PATTERN;
      acc_reg      <= '0;
      bit_cnt_reg  <= '0;
      word_cnt_reg <= '0;
      m_data_reg   <= '0;
      m_valid_reg  <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (clken) begin
        if (state_reg == HUNT) begin
          window_reg <= window_shift;
          if (sync_hit) begin
            bit_cnt_reg  <= '0;
            word_cnt_reg <= '0;
          end
        end else begin
          acc_reg <= word_shift;
          if (bit_cnt_reg == BIT_LAST) begin
            bit_cnt_reg <= '0;
            if (last_word) begin
              word_cnt_reg <= '0;
              // Poison the window so the next frame needs a complete fresh sync.
              window_reg   <= ~SYNC_PATTERN;
            end else begin
              word_cnt_reg <= word_cnt_reg + 1'b1;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
      end

      if (load) begin
        m_data_reg  <= word_shift;
        m_valid_reg <= 1'b1;
      end else if (m_valid_reg && m_ready) begin
        m_valid_reg <= 1'b0;
      end

      if (drop)         overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
    end
  end

  assign m_data   = m_data_reg;
  assign m_valid  = m_valid_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_serial_deframer.sv
// Directed bench for serial_deframer: sync hunt, word assembly, gapped strobes,
// backpressure/overflow, simultaneous accept+load and reset mid-frame.
module tb_serial_deframer;

  logic        clk = 1'b0;
  logic        rst, clken, si, m_ready, ovf_clr;
  logic [31:0] m_data;
  logic        m_valid, locked, overflow;

  int total = 0;
  int bad   = 0;

  serial_deframer dut (
    .clk      (clk),
    .rst      (rst),
    .clken    (clken),
    .si       (si),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .locked   (locked),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One qualified bit; outputs are sampled 1 time unit after the edge.
  task automatic strobe(input logic b);
    clken = 1'b1;
    si    = b;
    @(posedge clk);
    #1;
    clken = 1'b0;
  endtask

  task automatic idle();
    clken = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Eight zero bits flush the window, then the sync pattern MSB-first.
  task automatic send_sync(input bit gap);
    logic [7:0] p;
    p = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      strobe(1'b0);
      if (gap) idle();
    end
    check("locked_after_flush", {31'd0, locked}, 32'd0);
    for (int i = 7; i >= 0; i--) begin
      strobe(p[i]);
      if (i == 1) check("locked_before_sync_end", {31'd0, locked}, 32'd0);
      if (i == 0) check("locked_after_sync", {31'd0, locked}, 32'd1);
      if (gap) idle();
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap, input bit exp_load, input bit last);
    for (int i = 31; i >= 0; i--) begin
      if (i == 0 && m_ready) check("valid_before_last_bit", {31'd0, m_valid}, 32'd0);
      strobe(w[i]);
      if (i == 0) begin
        if (exp_load) begin
          check("valid_after_word", {31'd0, m_valid}, 32'd1);
          check("data_after_word", m_data, w);
        end
        check("locked_after_word", {31'd0, locked}, last ? 32'd0 : 32'd1);
        $display("word sent=%h m_data=%h m_valid=%0d overflow=%0d locked=%0d",
                 w, m_data, m_valid, overflow, locked);
      end
      if (gap) idle();
    end
  endtask

  task automatic send_frame(input bit gap);
    send_sync(gap);
    send_word(32'hDEADBEEF, gap, 1'b1, 1'b0);
    send_word(32'h12345678, gap, 1'b1, 1'b0);
    send_word(32'h00000000, gap, 1'b1, 1'b0);
    send_word(32'hFFFFFFFF, gap, 1'b1, 1'b1);
  endtask

  initial begin
    logic [31:0] w2;
    rst = 1'b1; clken = 1'b0; si = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_locked",   {31'd0, locked},   32'd0);
    check("reset_valid",    {31'd0, m_valid},  32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    check("reset_data",     m_data,            32'd0);
    rst = 1'b0;

    // Idle: no strobes, then 40 zero bits must never lock or emit.
    repeat (10) idle();
    for (int i = 0; i < 40; i++) begin
      strobe(1'b0);
      check("idle_locked", {31'd0, locked}, 32'd0);
      check("idle_valid",  {31'd0, m_valid}, 32'd0);
    end
    check("idle_overflow", {31'd0, overflow}, 32'd0);

    // Basic back-to-back frame with the consumer always ready.
    m_ready = 1'b1;
    send_frame(1'b0);
    idle();
    check("basic_valid_drained", {31'd0, m_valid}, 32'd0);
    check("basic_overflow", {31'd0, overflow}, 32'd0);

    // Same frame with a dead cycle after every strobe.
    send_frame(1'b1);
    check("gap_valid_drained", {31'd0, m_valid}, 32'd0);

    // Backpressure: first word held, the rest dropped.
    m_ready = 1'b0;
    send_sync(1'b0);
    send_word(32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    check("bp_overflow_w1", {31'd0, overflow}, 32'd0);
    send_word(32'h12345678, 1'b0, 1'b0, 1'b0);
    check("bp_overflow_w2", {31'd0, overflow}, 32'd1);
    check("bp_data_w2",     m_data, 32'hDEADBEEF);
    check("bp_valid_w2",    {31'd0, m_valid}, 32'd1);
    ovf_clr = 1'b1;  // clear held across word 3: the drop on its last bit must win
    send_word(32'h00000000, 1'b0, 1'b0, 1'b0);
    check("bp_drop_beats_clr", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b0;
    send_word(32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    check("bp_data_w4",     m_data, 32'hDEADBEEF);
    check("bp_overflow_w4", {31'd0, overflow}, 32'd1);
    m_ready = 1'b1;
    idle();
    check("bp_valid_drained", {31'd0, m_valid}, 32'd0);
    check("bp_data_holds",    m_data, 32'hDEADBEEF);
    m_ready = 1'b0;
    ovf_clr = 1'b1;
    idle();
    check("bp_overflow_cleared", {31'd0, overflow}, 32'd0);
    ovf_clr = 1'b0;

    // Accept of word 1 lands on the same edge that completes word 2.
    send_sync(1'b0);
    send_word(32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    w2 = 32'h12345678;
    for (int i = 31; i >= 1; i--) strobe(w2[i]);
    check("sim_data_held", m_data, 32'hDEADBEEF);
    m_ready = 1'b1;
    strobe(w2[0]);
    check("sim_data",     m_data, 32'h12345678);
    check("sim_valid",    {31'd0, m_valid}, 32'd1);
    check("sim_overflow", {31'd0, overflow}, 32'd0);
    send_word(32'h00000000, 1'b0, 1'b1, 1'b0);
    send_word(32'hFFFFFFFF, 1'b0, 1'b1, 1'b1);
    idle();

    // Reset mid-frame with a word still buffered.
    m_ready = 1'b0;
    send_sync(1'b0);
    send_word(32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    for (int i = 31; i >= 16; i--) strobe(w2[i]);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("midrst_locked", {31'd0, locked},  32'd0);
    check("midrst_valid",  {31'd0, m_valid}, 32'd0);
    check("midrst_data",   m_data,           32'd0);
    m_ready = 1'b1;
    send_frame(1'b0);
    idle();
    check("midrst_valid_drained", {31'd0, m_valid}, 32'd0);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
